// File: rtl/wb_write_queue.sv
// Write-back write queue: buffers WB-stage register writes and drains one per cycle.
// Optional pending-write lookup for read bypass is built when WBQ_BYPASS_EN is defined.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     rf_hold,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_waddr,
  output logic [DW-1:0]            rf_wdata,
  input  logic [AW-1:0]            lk_addr,
  output logic                     lk_hit,
  output logic [DW-1:0]            lk_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          acc;
  logic          push;
  logic          pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign in_ready = !full;
  assign count    = cnt;

  // r0 writes complete the handshake but are never stored
  assign acc  = in_valid && in_ready;
  assign push = acc && (in_addr != '0);
  assign pop  = !rf_hold && !empty;

  // Head/tail pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case (1'b1)
        (push && !pop): cnt <= cnt + CW'(1);
        (pop && !push): cnt <= cnt - CW'(1);
        default:        cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are qualified by count so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= in_addr;
      q_data[tail] <= in_data;
    end
  end

  // Register file write port, loaded from the head on each pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (pop) begin
      rf_we    <= 1'b1;
      rf_waddr <= q_addr[head];
      rf_wdata <= q_data[head];
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef WBQ_BYPASS_EN
  logic [PW-1:0] idx;

  // Youngest match wins: scan oldest to youngest, later hits overwrite
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = '0;
    if (rf_we && (rf_waddr == lk_addr)) begin
      lk_hit  = 1'b1;
      lk_data = rf_wdata;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < cnt) && (q_addr[idx] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = q_data[idx];
      end
    end
    if (lk_addr == '0) begin
      lk_hit  = 1'b0;
      lk_data = '0;
    end
  end
`else
  logic unused_lk;

  assign unused_lk = ^lk_addr;
  assign lk_hit    = 1'b0;
  assign lk_data   = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue.
// Reference model: a queue of pending writes plus the expected output register.
module tb_wb_write_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          rf_hold;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] lk_addr;
  logic          lk_hit;
  logic [DW-1:0] lk_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           pend[$];
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data),
    .rf_hold(rf_hold), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    pend.delete();
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  // Advance the model by one edge using the currently driven inputs
  task automatic tick();
    wr_t e;
    bit  acc;
    bit  pop;
    acc = in_valid && (pend.size() < DEPTH);
    pop = !rf_hold && (pend.size() > 0);
    if (pop) begin
      e       = pend.pop_front();
      m_we    = 1'b1;
      m_waddr = e.a;
      m_wdata = e.d;
    end else begin
      m_we = 1'b0;
    end
    if (acc && in_addr != '0) begin
      e.a = in_addr;
      e.d = in_data;
      pend.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void m_look(input logic [AW-1:0] a,
                                 output logic h,
                                 output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
`ifdef WBQ_BYPASS_EN
    if (a != '0) begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (!h && pend[i].a == a) begin
          h = 1'b1;
          d = pend[i].d;
        end
      end
      if (!h && m_we && m_waddr == a) begin
        h = 1'b1;
        d = m_wdata;
      end
    end
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_data = '0;
    rf_hold = 1'b0; lk_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rf_we !== 1'b0 || count !== '0 || in_ready !== 1'b1 ||
        empty !== 1'b1 || full !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      n_bad++;
      $display("FAIL reset_vals: we=%b cnt=%0d rdy=%b emp=%b full=%b wa=%0d wd=%h",
               rf_we, count, in_ready, empty, full, rf_waddr, rf_wdata);
    end
    rst_n = 1'b1;
    rf_hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_addr = AW'(10 + i); in_data = DW'(32'h100 + i);
      tick();
    end
    in_valid = 1'b0;
    rf_hold = 1'b0;
    tick();
    n_cmp++;
    if (rf_we !== 1'b1 || count !== CW'(2)) begin
      n_bad++;
      $display("FAIL reset_pre: we=%b cnt=%0d want we=1 cnt=2", rf_we, count);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rf_we !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_async: we=%b cnt=%0d rdy=%b want 0/0/1",
               rf_we, count, in_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (rf_we !== 1'b0 || count !== '0) begin
        n_bad++;
        $display("FAIL reset_after: cyc=%0d we=%b cnt=%0d want 0/0", i, rf_we, count);
      end
    end
  endtask

  task automatic test_single();
    rf_hold = 1'b0;
    in_valid = 1'b1; in_addr = AW'(5); in_data = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early: we=%b want 0", rf_we);
    end
    tick();
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== AW'(5) || rf_wdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL single_write: we=%b wa=%0d wd=%h want 1/5/deadbeef",
               rf_we, rf_waddr, rf_wdata);
    end
    tick();
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_bad++;
      $display("FAIL single_after: we=%b want 0", rf_we);
    end
  endtask

  task automatic test_fill();
    rf_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_addr = AW'(i); in_data = DW'(32'hF00 + i);
      tick();
    end
    n_cmp++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== CW'(4)) begin
      n_bad++;
      $display("FAIL fill_full: full=%b rdy=%b cnt=%0d want 1/0/4", full, in_ready, count);
    end
    in_addr = AW'(20); in_data = 32'hBAD;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (count !== CW'(4) || rf_we !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_fifth: cnt=%0d we=%b want 4/0", count, rf_we);
    end
    rf_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++;
      if (rf_we !== 1'b1 || rf_waddr !== AW'(i) || rf_wdata !== DW'(32'hF00 + i)) begin
        n_bad++;
        $display("FAIL fill_drain: k=%0d we=%b wa=%0d wd=%h", i, rf_we, rf_waddr, rf_wdata);
      end
    end
    n_cmp++;
    if (empty !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_empty: empty=%b want 1", empty);
    end
    tick();
  endtask

  task automatic test_r0();
    int peak;
    peak = 0;
    rf_hold = 1'b0;
    in_valid = 1'b1; in_addr = '0; in_data = 32'h1234;
    tick();
    if (int'(count) > peak) peak = int'(count);
    n_cmp++;
    if (count !== '0 || rf_we !== 1'b0) begin
      n_bad++;
      $display("FAIL r0_drop: cnt=%0d we=%b want 0/0", count, rf_we);
    end
    in_addr = AW'(7); in_data = 32'h55;
    tick();
    if (int'(count) > peak) peak = int'(count);
    in_valid = 1'b0;
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_bad++;
      $display("FAIL r0_nowrite: we=%b wa=%0d want 0", rf_we, rf_waddr);
    end
    tick();
    if (int'(count) > peak) peak = int'(count);
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== AW'(7) || rf_wdata !== 32'h55 || peak != 1) begin
      n_bad++;
      $display("FAIL r0_r7: we=%b wa=%0d wd=%h peak=%0d want 1/7/55/1",
               rf_we, rf_waddr, rf_wdata, peak);
    end
    tick();
  endtask

  task automatic test_wrap();
    wr_t s[10];
    rf_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s[i].a = AW'($urandom_range(1, 31));
      s[i].d = $urandom;
      in_valid = 1'b1; in_addr = s[i].a; in_data = s[i].d;
      tick();
      n_cmp++;
      if (int'(count) > 1) begin
        n_bad++;
        $display("FAIL wrap_count: i=%0d cnt=%0d want <=1", i, count);
      end
      if (i > 0) begin
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== s[i-1].a || rf_wdata !== s[i-1].d) begin
          n_bad++;
          $display("FAIL wrap_seq: i=%0d we=%b wa=%0d wd=%h want 1/%0d/%h",
                   i - 1, rf_we, rf_waddr, rf_wdata, s[i-1].a, s[i-1].d);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== s[9].a || rf_wdata !== s[9].d) begin
      n_bad++;
      $display("FAIL wrap_last: we=%b wa=%0d wd=%h want 1/%0d/%h",
               rf_we, rf_waddr, rf_wdata, s[9].a, s[9].d);
    end
    tick();
  endtask

  task automatic test_bypass();
    logic          eh;
    logic [DW-1:0] ed;
    rf_hold = 1'b1;
    in_valid = 1'b1; in_addr = AW'(9); in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    in_valid = 1'b0;
    lk_addr = AW'(9);
    #1;
`ifdef WBQ_BYPASS_EN
    eh = 1'b1; ed = 32'hB;
`else
    eh = 1'b0; ed = '0;
`endif
    n_cmp++;
    if (lk_hit !== eh || lk_data !== ed) begin
      n_bad++;
      $display("FAIL bypass_r9: hit=%b data=%h want %b/%h", lk_hit, lk_data, eh, ed);
    end
    lk_addr = '0;
    #1;
    n_cmp++;
    if (lk_hit !== 1'b0 || lk_data !== '0) begin
      n_bad++;
      $display("FAIL bypass_r0: hit=%b data=%h want 0/0", lk_hit, lk_data);
    end
    rf_hold = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic          eh;
    logic [DW-1:0] ed;
    for (int c = 0; c < 300; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 7));
      in_data  = $urandom;
      rf_hold  = ($urandom_range(0, 3) == 0);
      n_cmp++;
      if (in_ready !== (pend.size() < DEPTH)) begin
        n_bad++;
        $display("FAIL rnd_ready: c=%0d rdy=%b occ=%0d", c, in_ready, pend.size());
      end
      tick();
      n_cmp++;
      if (rf_we !== m_we || (m_we && (rf_waddr !== m_waddr || rf_wdata !== m_wdata))) begin
        n_bad++;
        $display("FAIL rnd_out: c=%0d we=%b wa=%0d wd=%h want %b/%0d/%h",
                 c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
      n_cmp++;
      if (int'(count) != pend.size() || empty !== (pend.size() == 0) ||
          full !== (pend.size() == DEPTH)) begin
        n_bad++;
        $display("FAIL rnd_occ: c=%0d cnt=%0d emp=%b full=%b want %0d",
                 c, count, empty, full, pend.size());
      end
      lk_addr = AW'($urandom_range(0, 7));
      #1;
      m_look(lk_addr, eh, ed);
      n_cmp++;
      if (lk_hit !== eh || lk_data !== ed) begin
        n_bad++;
        $display("FAIL rnd_lookup: c=%0d a=%0d hit=%b data=%h want %b/%h",
                 c, lk_addr, lk_hit, lk_data, eh, ed);
      end
    end
    in_valid = 1'b0;
    rf_hold  = 1'b0;
    repeat (DEPTH + 2) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_fill();
    test_r0();
    test_wrap();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
